flash_alarm_ctrl: RTL

Display-flash and alarm sequencer for the countdown timer.
- Edit mode: blinks the digit currently being edited.
- Countdown expiry: runs a fixed number of beep/gap cycles, flashing the whole display in sync with the buzzer, until the sequence finishes or the user acknowledges.
- Sits between the countdown/edit FSM and the 7-segment and buzzer drivers. Owns a 1 ms timebase shared by every timed phase.

---
 rtl/flash_alarm_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/flash_alarm_ctrl.sv
// Display-flash and alarm sequencer: edit-digit blink, beep/gap alarm, shared 1 ms timebase.
// Optional BUZZ_TONE_EN: square-wave buzzer at TONE_HZ during BEEP instead of a constant level.
module flash_alarm_ctrl #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned NDIG        = 4,
  parameter int unsigned BLINK_MS    = 500,
  parameter int unsigned BEEP_ON_MS  = 200,
  parameter int unsigned BEEP_OFF_MS = 300,
  parameter int unsigned BEEPS       = 5,
  parameter int unsigned TONE_HZ     = 2000,
  localparam int unsigned SEL_W      = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edit,
  input  logic [SEL_W-1:0] sel,
  input  logic             expired,
  input  logic             ack,
  output logic [NDIG-1:0]  blank,
  output logic             buzzer,
  output logic             alarm_active,
  output logic [1:0]       state
);

  localparam int unsigned P       = CLK_HZ / 1000;
  localparam int unsigned PRE_W   = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned MS_MAX1 = (BLINK_MS > BEEP_ON_MS) ? BLINK_MS : BEEP_ON_MS;
  localparam int unsigned MS_MAX  = (MS_MAX1 > BEEP_OFF_MS) ? MS_MAX1 : BEEP_OFF_MS;
  localparam int unsigned MS_W    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int unsigned BC_W    = $clog2(BEEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    BEEP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            st_q, st_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              phase_q, phase_d;
  logic [SEL_W-1:0]  sel_q;
  logic [NDIG-1:0]   blank_d;
  logic              buzz_d;
  logic              alarm_d;
  logic              ms_tick;
  logic              clr;

`ifdef BUZZ_TONE_EN
  localparam int unsigned HALF0  = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned HALF   = (HALF0 < 1) ? 1 : HALF0;
  localparam int unsigned TONE_W = (HALF > 1) ? $clog2(HALF) : 1;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
`else
  logic unused_tone;
  assign unused_tone = ^TONE_HZ;
`endif

  assign ms_tick = (pre_q == PRE_W'(P - 1));
  assign state   = st_q;

  // Next state, counters and registered outputs
  always_comb begin
    st_d    = st_q;
    bc_d    = bc_q;
    phase_d = phase_q;
    clr     = 1'b0;
    pre_d   = ms_tick ? '0 : PRE_W'(pre_q + 1'b1);
    ms_d    = ms_tick ? MS_W'(ms_q + 1'b1) : ms_q;
    blank_d = '0;
    alarm_d = 1'b0;
    buzz_d  = 1'b0;

    case (st_q)
      IDLE: begin
        pre_d = '0;
        ms_d  = '0;
        if (expired) begin
          st_d = BEEP;
          bc_d = '0;
          clr  = 1'b1;
        end else if (edit) begin
          st_d = EDIT;
          clr  = 1'b1;
        end
      end
      EDIT: begin
        if (expired) begin
          st_d = BEEP;
          bc_d = '0;
          clr  = 1'b1;
        end else if (!edit) begin
          st_d = IDLE;
          clr  = 1'b1;
        end else if (sel != sel_q) begin
          clr = 1'b1;
        end else if (ms_tick && ms_q == MS_W'(BLINK_MS - 1)) begin
          phase_d = ~phase_q;
          ms_d    = '0;
        end
      end
      BEEP: begin
        if (expired) begin
          bc_d = '0;
          clr  = 1'b1;
        end else if (ack) begin
          st_d = IDLE;
          clr  = 1'b1;
        end else if (ms_tick && ms_q == MS_W'(BEEP_ON_MS - 1)) begin
          st_d = GAP;
          bc_d = BC_W'(bc_q + 1'b1);
          clr  = 1'b1;
        end
      end
      GAP: begin
        if (expired) begin
          st_d = BEEP;
          bc_d = '0;
          clr  = 1'b1;
        end else if (ack) begin
          st_d = IDLE;
          clr  = 1'b1;
        end else if (ms_tick && ms_q == MS_W'(BEEP_OFF_MS - 1)) begin
          st_d = (bc_q == BC_W'(BEEPS)) ? IDLE : BEEP;
          clr  = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    // Every entry (and sel change) restarts timing with the blink phase visible
    if (clr) begin
      pre_d   = '0;
      ms_d    = '0;
      phase_d = 1'b0;
    end

    case (st_d)
      EDIT: if (phase_d && (32'(sel) < NDIG)) blank_d = NDIG'(1) << sel;
      BEEP: alarm_d = 1'b1;
      GAP: begin
        blank_d = '1;
        alarm_d = 1'b1;
      end
      default: ;
    endcase

`ifdef BUZZ_TONE_EN
    tone_cnt_d = '0;
    if (st_d == BEEP) begin
      if (clr) begin
        buzz_d = 1'b1;
      end else if (tone_cnt_q == TONE_W'(HALF - 1)) begin
        buzz_d = ~buzzer;
      end else begin
        tone_cnt_d = TONE_W'(tone_cnt_q + 1'b1);
        buzz_d     = buzzer;
      end
    end
`else
    buzz_d = (st_d == BEEP);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= IDLE;
      pre_q        <= '0;
      ms_q         <= '0;
      bc_q         <= '0;
      phase_q      <= 1'b0;
      sel_q        <= '0;
      blank        <= '0;
      buzzer       <= 1'b0;
      alarm_active <= 1'b0;
`ifdef BUZZ_TONE_EN
      tone_cnt_q   <= '0;
`endif
    end else begin
      st_q         <= st_d;
      pre_q        <= pre_d;
      ms_q         <= ms_d;
      bc_q         <= bc_d;
      phase_q      <= phase_d;
      sel_q        <= sel;
      blank        <= blank_d;
      buzzer       <= buzz_d;
      alarm_active <= alarm_d;
`ifdef BUZZ_TONE_EN
      tone_cnt_q   <= tone_cnt_d;
`endif
    end
  end

endmodule
